tilelink_arbiter: RTL

N-to-1 TileLink Uncached (TL-UL) arbiter. Several client masters, for example the instruction fetch, data and debug ports, share one manager port. It arbitrates Channel A with round-robin priority and locks the grant across stalls and multi-beat Put bursts. It extends `a_source` with the client index and routes Channel D responses back to the issuing client using that index. It sits between core-side TL masters and the single memory/peripheral TL manager.

---
 rtl/tilelink_arbiter_pkg.sv | 49 ++++
 rtl/tilelink_arbiter_if.sv | 97 +++++++++
 rtl/tilelink_rr_picker.sv | 37 +++
 rtl/tilelink_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tilelink_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : tilelink_arbiter_pkg
// Brief   : TL-UL opcodes, arbiter FSM state type and beat-count helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package tilelink_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_ADDR_WIDTH      = 32;
    localparam int DEFAULT_TL_SOURCE_WIDTH = 4;
    localparam int DEFAULT_TL_SINK_WIDTH   = 1;
    localparam int DEFAULT_TL_SIZE_WIDTH   = 3;

    localparam int TL_OPCODE_WIDTH  = 3;
    localparam int TL_A_PARAM_WIDTH = 3;
    localparam int TL_D_PARAM_WIDTH = 2;

    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_ARITHMETIC_DATA  = 3'd2;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_LOGICAL_DATA     = 3'd3;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_GET              = 3'd4;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_A_INTENT           = 3'd5;

    localparam logic [TL_OPCODE_WIDTH-1:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [TL_OPCODE_WIDTH-1:0] TL_D_HINT_ACK        = 3'd2;

    typedef enum logic [1:0] {
        TL_ARB_IDLE  = 2'd0,
        TL_ARB_STALL = 2'd1,
        TL_ARB_BURST = 2'd2
    } tl_arb_state_e;

    // Only data-carrying A messages larger than one bus beat span several beats.
    function automatic int unsigned tl_beats(input logic [TL_OPCODE_WIDTH-1:0] opcode,
                                             input int unsigned size,
                                             input int unsigned lg_beat_bytes);
        if ((opcode <= TL_A_LOGICAL_DATA) && (size > lg_beat_bytes))
            return 32'd1 << (size - lg_beat_bytes);
        return 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tilelink_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : tilelink_arbiter_if
// Brief   : Bundle of per-client and manager TL-UL A/D channels around the arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface tilelink_arbiter_if
    import tilelink_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS  = 2,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int SOURCE_WIDTH = DEFAULT_TL_SOURCE_WIDTH,
    parameter int SINK_WIDTH   = DEFAULT_TL_SINK_WIDTH,
    parameter int SIZE_WIDTH   = DEFAULT_TL_SIZE_WIDTH
) ();
    localparam int IDX_W          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int M_SOURCE_WIDTH = SOURCE_WIDTH + IDX_W;
    localparam int MASK_WIDTH     = DATA_WIDTH / 8;

    logic [NUM_CLIENTS-1:0][TL_OPCODE_WIDTH-1:0]  c_a_opcode;
    logic [NUM_CLIENTS-1:0][TL_A_PARAM_WIDTH-1:0] c_a_param;
    logic [NUM_CLIENTS-1:0][SIZE_WIDTH-1:0]       c_a_size;
    logic [NUM_CLIENTS-1:0][SOURCE_WIDTH-1:0]     c_a_source;
    logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0]       c_a_address;
    logic [NUM_CLIENTS-1:0][MASK_WIDTH-1:0]       c_a_mask;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]       c_a_data;
    logic [NUM_CLIENTS-1:0]                       c_a_corrupt;
    logic [NUM_CLIENTS-1:0]                       c_a_valid;
    logic [NUM_CLIENTS-1:0]                       c_a_ready;

    logic [NUM_CLIENTS-1:0][TL_OPCODE_WIDTH-1:0]  c_d_opcode;
    logic [NUM_CLIENTS-1:0][TL_D_PARAM_WIDTH-1:0] c_d_param;
    logic [NUM_CLIENTS-1:0][SIZE_WIDTH-1:0]       c_d_size;
    logic [NUM_CLIENTS-1:0][SOURCE_WIDTH-1:0]     c_d_source;
    logic [NUM_CLIENTS-1:0][SINK_WIDTH-1:0]       c_d_sink;
    logic [NUM_CLIENTS-1:0]                       c_d_denied;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]       c_d_data;
    logic [NUM_CLIENTS-1:0]                       c_d_corrupt;
    logic [NUM_CLIENTS-1:0]                       c_d_valid;
    logic [NUM_CLIENTS-1:0]                       c_d_ready;

    logic [TL_OPCODE_WIDTH-1:0]  m_a_opcode;
    logic [TL_A_PARAM_WIDTH-1:0] m_a_param;
    logic [SIZE_WIDTH-1:0]       m_a_size;
    logic [M_SOURCE_WIDTH-1:0]   m_a_source;
    logic [ADDR_WIDTH-1:0]       m_a_address;
    logic [MASK_WIDTH-1:0]       m_a_mask;
    logic [DATA_WIDTH-1:0]       m_a_data;
    logic                        m_a_corrupt;
    logic                        m_a_valid;
    logic                        m_a_ready;

    logic [TL_OPCODE_WIDTH-1:0]  m_d_opcode;
    logic [TL_D_PARAM_WIDTH-1:0] m_d_param;
    logic [SIZE_WIDTH-1:0]       m_d_size;
    logic [M_SOURCE_WIDTH-1:0]   m_d_source;
    logic [SINK_WIDTH-1:0]       m_d_sink;
    logic                        m_d_denied;
    logic [DATA_WIDTH-1:0]       m_d_data;
    logic                        m_d_corrupt;
    logic                        m_d_valid;
    logic                        m_d_ready;

    logic                        route_err;

    // Arbiter view.
    modport slave (
        input  c_a_opcode, c_a_param, c_a_size, c_a_source, c_a_address,
               c_a_mask, c_a_data, c_a_corrupt, c_a_valid, c_d_ready,
               m_a_ready, m_d_opcode, m_d_param, m_d_size, m_d_source,
               m_d_sink, m_d_denied, m_d_data, m_d_corrupt, m_d_valid,
        output c_a_ready, c_d_opcode, c_d_param, c_d_size, c_d_source,
               c_d_sink, c_d_denied, c_d_data, c_d_corrupt, c_d_valid,
               m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
               m_a_mask, m_a_data, m_a_corrupt, m_a_valid, m_d_ready,
               route_err
    );

    // Environment view: clients plus manager.
    modport master (
        output c_a_opcode, c_a_param, c_a_size, c_a_source, c_a_address,
               c_a_mask, c_a_data, c_a_corrupt, c_a_valid, c_d_ready,
               m_a_ready, m_d_opcode, m_d_param, m_d_size, m_d_source,
               m_d_sink, m_d_denied, m_d_data, m_d_corrupt, m_d_valid,
        input  c_a_ready, c_d_opcode, c_d_param, c_d_size, c_d_source,
               c_d_sink, c_d_denied, c_d_data, c_d_corrupt, c_d_valid,
               m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
               m_a_mask, m_a_data, m_a_corrupt, m_a_valid, m_d_ready,
               route_err
    );

endinterface

`default_nettype wire

// File: rtl/tilelink_rr_picker.sv
//------------------------------------------------------------------------------
// Module  : tilelink_rr_picker
// Brief   : Round-robin first-one finder searching upward from a pointer.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tilelink_rr_picker #(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic [IDX_W-1:0]       o_winner_idx,
    output logic                   o_any
);

    int w_idx;

    // Scan from farthest to nearest so the closest request at/above the pointer wins last.
    always_comb begin
        o_winner_idx = '0;
        o_any        = 1'b0;
        w_idx        = 0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_CLIENTS;
            if (i_req[w_idx]) begin
                o_winner_idx = IDX_W'(w_idx);
                o_any        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tilelink_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tilelink_arbiter
// Brief   : N-to-1 TL-UL arbiter, round-robin on A with stall/burst lock, D routed by source index.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tilelink_arbiter
    import tilelink_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS  = 2,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int SOURCE_WIDTH = DEFAULT_TL_SOURCE_WIDTH,
    parameter int SINK_WIDTH   = DEFAULT_TL_SINK_WIDTH,
    parameter int SIZE_WIDTH   = DEFAULT_TL_SIZE_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    tilelink_arbiter_if.slave     bus
);

    localparam int IDX_W          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int M_SOURCE_WIDTH = SOURCE_WIDTH + IDX_W;
    localparam int LG_BEAT_BYTES  = $clog2(DATA_WIDTH / 8);
    localparam int BEATS_W        = SIZE_WIDTH + 1;

    tl_arb_state_e        r_state;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [BEATS_W-1:0]   r_beats_left;
    logic                 r_route_err;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_any;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_sel_valid;
    logic                 w_accept;
    int unsigned          w_beats;
    logic                 w_multi;
    logic [BEATS_W-1:0]   w_beats_m1;
    logic [IDX_W-1:0]     w_d_idx;
    logic                 w_d_hit;

    function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_CLIENTS - 1) ? '0 : IDX_W'(int'(idx) + 1);
    endfunction

    tilelink_rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req        (bus.c_a_valid),
        .i_rr_ptr     (r_rr_ptr),
        .o_winner_idx (w_winner),
        .o_any        (w_any)
    );

    // Outside IDLE the mux is locked so the manager sees stable fields.
    assign w_sel       = (r_state == TL_ARB_IDLE) ? w_winner : r_grant_idx;
    assign w_sel_valid = (r_state == TL_ARB_IDLE) ? w_any : bus.c_a_valid[r_grant_idx];
    assign w_accept    = resetn & w_sel_valid & bus.m_a_ready;
    assign w_beats     = tl_beats(bus.c_a_opcode[w_sel], 32'(bus.c_a_size[w_sel]), LG_BEAT_BYTES);
    assign w_multi     = (w_beats > 32'd1);
    assign w_beats_m1  = BEATS_W'(w_beats - 32'd1);

    assign bus.m_a_valid   = resetn & w_sel_valid;
    assign bus.m_a_opcode  = bus.c_a_opcode[w_sel];
    assign bus.m_a_param   = bus.c_a_param[w_sel];
    assign bus.m_a_size    = bus.c_a_size[w_sel];
    assign bus.m_a_source  = {w_sel, bus.c_a_source[w_sel]};
    assign bus.m_a_address = bus.c_a_address[w_sel];
    assign bus.m_a_mask    = bus.c_a_mask[w_sel];
    assign bus.m_a_data    = bus.c_a_data[w_sel];
    assign bus.m_a_corrupt = bus.c_a_corrupt[w_sel];

    always_comb begin
        bus.c_a_ready        = '0;
        bus.c_a_ready[w_sel] = resetn & bus.m_a_ready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= TL_ARB_IDLE;
            r_grant_idx  <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
            r_route_err  <= 1'b0;
        end else begin
            r_route_err <= bus.m_d_valid & ~w_d_hit;
            case (r_state)
                TL_ARB_IDLE: begin
                    if (w_any) begin
                        if (!bus.m_a_ready) begin
                            r_grant_idx <= w_winner;
                            r_state     <= TL_ARB_STALL;
                        end else if (w_multi) begin
                            r_grant_idx  <= w_winner;
                            r_beats_left <= w_beats_m1;
                            r_state      <= TL_ARB_BURST;
                        end else begin
                            r_rr_ptr <= f_next_idx(w_winner);
                        end
                    end
                end
                TL_ARB_STALL: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_beats_left <= w_beats_m1;
                            r_state      <= TL_ARB_BURST;
                        end else begin
                            r_rr_ptr <= f_next_idx(r_grant_idx);
                            r_state  <= TL_ARB_IDLE;
                        end
                    end
                end
                TL_ARB_BURST: begin
                    if (w_accept) begin
                        if (r_beats_left == BEATS_W'(1)) begin
                            r_rr_ptr <= f_next_idx(r_grant_idx);
                            r_state  <= TL_ARB_IDLE;
                        end else begin
                            r_beats_left <= r_beats_left - BEATS_W'(1);
                        end
                    end
                end
                default: r_state <= TL_ARB_IDLE;
            endcase
        end
    end

    // D channel: index field selects the client; unknown indices are swallowed.
    assign w_d_idx = bus.m_d_source[M_SOURCE_WIDTH-1 -: IDX_W];
    assign w_d_hit = (int'(w_d_idx) < NUM_CLIENTS);

    assign bus.c_d_opcode  = {NUM_CLIENTS{bus.m_d_opcode}};
    assign bus.c_d_param   = {NUM_CLIENTS{bus.m_d_param}};
    assign bus.c_d_size    = {NUM_CLIENTS{bus.m_d_size}};
    assign bus.c_d_source  = {NUM_CLIENTS{bus.m_d_source[SOURCE_WIDTH-1:0]}};
    assign bus.c_d_sink    = {NUM_CLIENTS{bus.m_d_sink}};
    assign bus.c_d_denied  = {NUM_CLIENTS{bus.m_d_denied}};
    assign bus.c_d_data    = {NUM_CLIENTS{bus.m_d_data}};
    assign bus.c_d_corrupt = {NUM_CLIENTS{bus.m_d_corrupt}};

    always_comb begin
        bus.c_d_valid = '0;
        if (resetn && w_d_hit)
            bus.c_d_valid[w_d_idx] = bus.m_d_valid;
    end

    assign bus.m_d_ready = resetn & (w_d_hit ? bus.c_d_ready[w_d_idx] : 1'b1);
    assign bus.route_err = r_route_err;

endmodule

`default_nettype wire
